fft8_input_framer: RTL and testbench

//  Upstream stage of fft_8point. Converts a serial stream of real Q16.16 samples into
//  8-sample parallel frames on in0_r..in7_r. Ping-pong banked, so streaming continues

---
 rtl/fft8_input_framer_if.sv | 39 +++
 rtl/fft8_input_framer.sv | 85 ++++++++
 tb/tb_fft8_input_framer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft8_input_framer_if.sv
// Handshake bundles for the fft8 input framer.
// sample_if carries the serial stream; frame_if carries the parallel frame.
interface sample_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              last;
    logic              ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

interface frame_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in0_r;
    logic [DATA_W-1:0] in1_r;
    logic [DATA_W-1:0] in2_r;
    logic [DATA_W-1:0] in3_r;
    logic [DATA_W-1:0] in4_r;
    logic [DATA_W-1:0] in5_r;
    logic [DATA_W-1:0] in6_r;
    logic [DATA_W-1:0] in7_r;
    logic              valid;
    logic              ready;

    modport master (
        output in0_r, output in1_r, output in2_r, output in3_r,
        output in4_r, output in5_r, output in6_r, output in7_r,
        output valid, input ready
    );
    modport slave (
        input in0_r, input in1_r, input in2_r, input in3_r,
        input in4_r, input in5_r, input in6_r, input in7_r,
        input valid, output ready
    );
endinterface

// File: rtl/fft8_input_framer.sv
// Ping-pong serial-to-parallel framer feeding fft_8point.
// Two 8-sample banks: one fills while the other waits for release.
module fft8_input_framer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    sample_if.slave          s,
    frame_if.master          f,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt
);

    logic [DATA_W-1:0] bank [2][8];
    logic [1:0]        full;
    logic              wr_sel;
    logic              rd_sel;
    logic [2:0]        wr_idx;
    logic              acc;
    logic              rel;
    logic              last_pos;

    assign s.ready  = !full[wr_sel];
    assign f.valid  = full[rd_sel];
    assign acc      = s.valid && s.ready;
    assign rel      = f.valid && f.ready;
    assign last_pos = (wr_idx == 3'd7);

    assign f.in0_r = bank[rd_sel][0];
    assign f.in1_r = bank[rd_sel][1];
    assign f.in2_r = bank[rd_sel][2];
    assign f.in3_r = bank[rd_sel][3];
    assign f.in4_r = bank[rd_sel][4];
    assign f.in5_r = bank[rd_sel][5];
    assign f.in6_r = bank[rd_sel][6];
    assign f.in7_r = bank[rd_sel][7];

    // Sample storage: write the accepted sample unless it is a premature last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 8; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else if (acc && !(s.last && !last_pos)) begin
            bank[wr_sel][wr_idx] <= s.data;
        end
    end

    // Bank bookkeeping: fill on the write side, release on the read side.
    // A filling bank is never full, so the two sides never touch the same bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full      <= 2'b00;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_idx    <= 3'd0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame_err <= 1'b0;
            if (acc) begin
                if (s.last && !last_pos) begin
                    wr_idx    <= 3'd0;
                    frame_err <= 1'b1;
                end else if (last_pos) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= ~wr_sel;
                    wr_idx       <= 3'd0;
                    frame_err    <= !s.last;
                end else begin
                    wr_idx <= wr_idx + 3'd1;
                end
            end
            if (rel) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
                frame_cnt    <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft8_input_framer.sv
// Scoreboard bench for fft8_input_framer.
// Frames are modelled from accepted samples and compared on release.
module tb_fft8_input_framer;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          frame_err;
    logic [CW-1:0] frame_cnt;

    sample_if #(.DATA_W(DW)) si ();
    frame_if  #(.DATA_W(DW)) fi ();

    fft8_input_framer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (si.slave),
        .f         (fi.master),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [255:0] q[$];
    logic [DW-1:0] part [8];
    int           pidx = 0;
    logic         err_exp = 1'b0;
    logic         hold = 1'b0;
    logic [255:0] snap = '0;
    logic [CW-1:0] mcnt = '0;
    int           rdy_mode = 0;
    int           cyc_used = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] outs();
        return {fi.in7_r, fi.in6_r, fi.in5_r, fi.in4_r,
                fi.in3_r, fi.in2_r, fi.in1_r, fi.in0_r};
    endfunction

    function automatic logic [255:0] pack_part();
        return {part[7], part[6], part[5], part[4],
                part[3], part[2], part[1], part[0]};
    endfunction

    // frame_ready driver: off, on, or random
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       fi.ready = 1'b0;
            1:       fi.ready = 1'b1;
            default: fi.ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    // Monitor: evaluates handshakes between edges and runs the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (err_exp || frame_err)
                check("frame_err", frame_err, err_exp);
            err_exp = 1'b0;
            if (hold)
                check("stable", outs(), snap);
            hold = fi.valid && !fi.ready;
            snap = outs();
            if (si.valid && si.ready) begin
                if (si.last && pidx != 7) begin
                    pidx    = 0;
                    err_exp = 1'b1;
                end else begin
                    part[pidx] = si.data;
                    if (pidx == 7) begin
                        q.push_back(pack_part());
                        err_exp = !si.last;
                        pidx    = 0;
                    end else begin
                        pidx++;
                    end
                end
            end
            if (fi.valid && fi.ready) begin
                if (q.size() == 0) check("spurious", 1, 0);
                else check("frame", outs(), q.pop_front());
                check("frame_cnt", frame_cnt, mcnt);
                mcnt = mcnt + 1'b1;
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic l);
        int  n;
        logic acc;
        si.data  = d;
        si.last  = l;
        si.valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = si.ready;
            n++;
            cyc_used++;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", acc, 1);
        si.valid = 1'b0;
        si.last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        rdy_mode = 1;
        n = 0;
        while ((q.size() != 0 || fi.valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        q.delete();
        pidx    = 0;
        err_exp = 1'b0;
        hold    = 1'b0;
        mcnt    = '0;
        #1;
        check("rst_valid", fi.valid, 0);
        check("rst_out", outs(), 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_ready", si.ready, 1);
        check("rst_err", frame_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] t1 [8];
        logic [255:0]  exp1;
        int            n;
        logic [CW-1:0] base;

        rst      = 1'b1;
        si.data  = '0;
        si.valid = 1'b0;
        si.last  = 1'b0;
        fi.ready = 1'b0;
        #2;
        do_reset();

        // 1: single frame of Q16.16 ones and zeros
        t1[0] = 32'h0001_0000; t1[1] = 32'h0001_0000;
        t1[2] = 32'h0001_0000; t1[3] = 32'h0;
        t1[4] = 32'h0001_0000; t1[5] = 32'h0;
        t1[6] = 32'h0;         t1[7] = 32'h0;
        exp1 = {t1[7], t1[6], t1[5], t1[4], t1[3], t1[2], t1[1], t1[0]};
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) send(t1[i], i == 7);
        check("t1_valid", fi.valid, 1);
        check("t1_data", outs(), exp1);
        drain();

        // 2: 24 samples with consumer stalled, then drain
        base = mcnt;
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) send(DW'(32'h100 + i), (i % 8) == 7);
        @(negedge clk);
        check("t2_full", si.ready, 0);
        check("t2_valid", fi.valid, 1);
        rdy_mode = 1;
        n = 0;
        while (frame_cnt != base + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rdy_mode = 0;
        @(posedge clk);
        #1;
        check("t2_cnt", frame_cnt, base + CW'(2));
        for (int i = 16; i < 24; i++) send(DW'(32'h100 + i), (i % 8) == 7);
        drain();

        // 3: continuous stream, no s_ready gaps
        rdy_mode = 1;
        cyc_used = 0;
        for (int i = 0; i < 64; i++) send(DW'(i % 8), (i % 8) == 7);
        check("t3_rate", cyc_used, 64);
        drain();

        // 4: premature s_last, then a clean frame
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) send(DW'(32'h500 + i), i == 4);
        @(negedge clk);
        check("t4_novalid", fi.valid, 0);
        for (int i = 0; i < 8; i++) send(DW'(32'h600 + i), i == 7);
        drain();
        // missing s_last on the 8th sample
        for (int i = 0; i < 8; i++) send(DW'(32'h700 + i), 1'b0);
        drain();

        // 5: reset mid-frame with one bank full
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) send(DW'(32'h800 + i), i == 7);
        for (int i = 0; i < 3; i++) send(DW'(32'h900 + i), 1'b0);
        check("t5_cnt_pre", frame_cnt, mcnt);
        do_reset();
        for (int i = 0; i < 8; i++) send(DW'(32'hA00 + i), i == 7);
        check("t5_valid", fi.valid, 1);
        drain();

        // 6: random stalls on both sides, 1000 frames
        rdy_mode = 2;
        for (int fr = 0; fr < 1000; fr++) begin
            for (int i = 0; i < 8; i++) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send($urandom(), i == 7);
            end
        end
        drain();
        check("t6_empty", q.size(), 0);
        check("t6_cnt", frame_cnt, mcnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
